// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg: shared arbiter state, owner encoding and SDRAM address width
package gb_mem_pkg;
  localparam int ADDR_W_DEF = 24;
  typedef enum logic [2:0] {ST_IDLE, ST_DL_WR, ST_CPU_RD, ST_CPU_WR, ST_BK_RD, ST_BK_WR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_CPU, OWN_BK} owner_t;
  function automatic owner_t owner_of(state_t s);
    return s == ST_DL_WR ? OWN_DL :
           (s == ST_CPU_RD || s == ST_CPU_WR) ? OWN_CPU :
           (s == ST_BK_RD || s == ST_BK_WR) ? OWN_BK : OWN_NONE;
  endfunction
endpackage

// File: rtl/cart_mem_arb.sv
// cart_mem_arb: slot-based SDRAM arbiter for ROM download, cart CPU and save-RAM backup
// Ports:
//   clk_sys, reset_n (async active-low), ce_cpu (slot boundary strobe, one per 8 clk)
//   dl_active, dl_req/dl_addr/dl_data -> dl_ack        ROM download word writes
//   cpu_rd/cpu_wr/cpu_addr/cpu_a0/cpu_din -> cpu_dout  cart byte access
//   bk_req/bk_we/bk_addr/bk_din -> bk_dout/bk_ack      backup word access at BK_BASE
//   sd_addr/sd_din/sd_ds/sd_we/sd_oe <- sd_dout         registered per-slot SDRAM command
module cart_mem_arb
  import gb_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BK_BASE = 24'h100000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_cpu,
  input  logic              dl_active,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_ack,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_a0,
  output logic [7:0]        cpu_dout,
  input  logic              bk_req,
  input  logic              bk_we,
  input  logic [ADDR_W-1:0] bk_addr,
  input  logic [15:0]       bk_din,
  output logic [15:0]       bk_dout,
  output logic              bk_ack,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_ds,
  output logic              sd_we,
  output logic              sd_oe,
  input  logic [15:0]       sd_dout
);
  state_t r_state, w_next;
  owner_t w_own_cur, w_own_nxt;
  logic r_a0;
  logic w_dl_ok, w_bk_ok;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0] w_din;
  logic [1:0] w_ds;
  assign w_own_cur = owner_of(r_state);
  assign w_own_nxt = owner_of(w_next);
  // A req still high at the boundary ending its own slot is the word just served,
  // since the requester only sees the ack afterwards; it is not re-granted.
  assign w_dl_ok = dl_req && w_own_cur != OWN_DL;
  assign w_bk_ok = bk_req && w_own_cur != OWN_BK;
  always_comb
    w_next = (dl_active && w_dl_ok) ? ST_DL_WR :
             (!dl_active && cpu_wr) ? ST_CPU_WR :
             (!dl_active && cpu_rd) ? ST_CPU_RD :
             w_bk_ok ? (bk_we ? ST_BK_WR : ST_BK_RD) : ST_IDLE;
  // Idle slots keep the previous address/data/lanes on the bus.
  always_comb begin
    w_addr = w_own_nxt == OWN_DL ? dl_addr :
             w_own_nxt == OWN_CPU ? cpu_addr :
             w_own_nxt == OWN_BK ? BK_BASE + bk_addr : sd_addr;
    w_din = w_next == ST_DL_WR ? dl_data :
            w_next == ST_CPU_WR ? {cpu_din, cpu_din} :
            w_next == ST_BK_WR ? bk_din : sd_din;
    w_ds = w_next == ST_CPU_WR ? {cpu_a0, ~cpu_a0} :
           w_next == ST_IDLE ? sd_ds : 2'b11;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_a0     <= 1'b0;
      dl_ack   <= 1'b0;
      bk_ack   <= 1'b0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_ds    <= '0;
      sd_we    <= 1'b0;
      sd_oe    <= 1'b0;
      cpu_dout <= '0;
      bk_dout  <= '0;
    end else begin
      dl_ack <= ce_cpu && w_own_cur == OWN_DL;
      bk_ack <= ce_cpu && w_own_cur == OWN_BK;
      if (ce_cpu) begin
        r_state <= w_next;
        r_a0    <= cpu_a0;
        sd_addr <= w_addr;
        sd_din  <= w_din;
        sd_ds   <= w_ds;
        sd_we   <= w_next inside {ST_DL_WR, ST_CPU_WR, ST_BK_WR};
        sd_oe   <= w_next inside {ST_CPU_RD, ST_BK_RD};
        if (r_state == ST_CPU_RD) cpu_dout <= r_a0 ? sd_dout[15:8] : sd_dout[7:0];
        if (r_state == ST_BK_RD) bk_dout <= sd_dout;
      end
    end
endmodule

// File: doc/cart_mem_arb.md
CART_MEM_ARB -- requirements
Module: cart_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, SDRAM word-address width.
REQ-002 SHALL have parameter BK_BASE, default 24'h100000, word base of cart-RAM region added to bk_addr.
REQ-003 clk_sys  in  1  system clock, all logic on rising edge.
REQ-004 reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 ce_cpu  in  1  one-clk slot strobe; one SDRAM access per slot (8 clk_sys).
REQ-006 dl_active  in  1  ROM download in progress; CPU held in reset.
REQ-007 dl_req / dl_addr / dl_data  in  1/ADDR_W/16  download word write request, address, data.
REQ-008 dl_ack  out  1  one-clk pulse, download word written.
REQ-009 cpu_rd / cpu_wr  in  1/1  cart read; qualified cart-RAM write (already bank/enable checked).
REQ-010 cpu_addr / cpu_din  in  ADDR_W/8  byte-granular word address plus byte select in cpu_a0; write byte.
REQ-011 cpu_a0  in  1  byte select (0 = low lane).
REQ-012 cpu_dout  out  8  read byte, held until next CPU read completes.
REQ-013 bk_req / bk_we / bk_addr / bk_din  in  1/1/ADDR_W/16  save-RAM backup word access from HPS side.
REQ-014 bk_dout / bk_ack  out  16/1  backup read word; one-clk completion pulse.
REQ-015 sd_addr / sd_din / sd_ds / sd_we / sd_oe  out  ADDR_W/16/2/1/1  SDRAM controller command for current slot.
REQ-016 sd_dout  in  16  SDRAM read data, valid at slot end.

Function
REQ-017 Owner SHALL be decided only on the clk_sys edge where ce_cpu=1; sd_* SHALL be registered and stable for the entire following slot.
REQ-018 States: IDLE, DL_WR, CPU_RD, CPU_WR, BK_RD, BK_WR; each non-IDLE state lasts exactly one slot.
REQ-019 Priority at slot boundary: dl_active&dl_req -> DL_WR; else !dl_active&cpu_wr -> CPU_WR; else !dl_active&cpu_rd -> CPU_RD; else bk_req -> BK_WR/BK_RD per bk_we; else IDLE.
REQ-020 While dl_active, CPU requests SHALL be ignored (no SDRAM access, cpu_dout unchanged).
REQ-021 CPU requests SHALL never wait: a CPU request present at a boundary is always granted when dl_active=0.
REQ-022 DL_WR: sd_addr=dl_addr, sd_din=dl_data, sd_ds=2'b11, sd_we=1, sd_oe=0.
REQ-023 CPU_RD: sd_addr=cpu_addr, sd_oe=1, sd_ds=2'b11; at the ending ce_cpu, cpu_dout = cpu_a0 ? sd_dout[15:8] : sd_dout[7:0].
REQ-024 CPU_WR: sd_din={cpu_din,cpu_din}, sd_ds={cpu_a0,~cpu_a0}, sd_we=1.
REQ-025 BK_*: sd_addr=BK_BASE+bk_addr (ADDR_W-bit wrap, carry dropped), sd_ds=2'b11; BK_RD latches sd_dout into bk_dout at slot end.
REQ-026 dl_ack/bk_ack SHALL pulse high for exactly the one clk_sys following the ce_cpu edge that ends their slot; requester SHALL drop/advance req on ack; a req still high after ack is a new request.
REQ-027 IDLE: sd_we=0, sd_oe=0, sd_addr/sd_din hold previous values.
REQ-028 dl_active falling mid-slot SHALL NOT abort the in-flight DL_WR; it completes and acks.
REQ-029 A bk_req pending while CPU owns slots SHALL be served in the first slot with no CPU request; no starvation counter.
REQ-030 Requests arriving between ce_cpu pulses SHALL be evaluated only at the next boundary; latency request-to-ack = 1 to 2 slots when uncontested.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, sd_we=0, sd_oe=0, dl_ack=0, bk_ack=0, sd_addr=0, sd_din=0, sd_ds=0, cpu_dout=8'h00, bk_dout=0, regardless of slot phase.
REQ-032 First grant after reset_n rises SHALL occur at the first ce_cpu edge; an access interrupted by reset SHALL NOT be acked or retried.

Structure
REQ-033 State enum, owner encoding and ADDR_W default SHALL live in shared package gb_mem_pkg.
REQ-034 Single module, no sub-modules; slot boundary taken solely from ce_cpu.

Verification
REQ-035 dl_active=1, dl_req with dl_addr=24'h000A3, dl_data=16'h1234 -> one DL_WR slot, sd_we=1, sd_ds=11, dl_ack one pulse after next ce_cpu.
REQ-036 cpu_rd, cpu_addr=24'h000080, cpu_a0=1, sd_dout=16'hBEEF -> cpu_dout=8'hBE after slot; cpu_a0=0 -> 8'hEF.
REQ-037 cpu_wr, cpu_din=8'h5A, cpu_a0=0 -> sd_din=16'h5A5A, sd_ds=2'b01, sd_we=1 for one slot only.
REQ-038 bk_req read (bk_addr=5) with cpu_rd asserted 3 consecutive slots -> bk served in 4th slot, sd_addr=24'h100005, bk_ack then.
REQ-039 dl_active=1 with cpu_rd and dl_req simultaneously -> DL_WR granted, no CPU_RD, cpu_dout unchanged.
REQ-040 reset_n pulsed low mid CPU_WR slot -> sd_we=0 within same cycle, no ack, IDLE until first ce_cpu after release.
